bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 141 ++++++++++++++
 tb/tb_bit_serializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: loads a WIDTH-bit word on a rising edge of `load` and
// shifts it out on ser_out. Each bit is held for TICK_DIV clk cycles. The
// ser_clk output rises halfway through each bit period, so a downstream
// detector can sample mid-bit. The FSM runs IDLE -> SHIFT -> DONE; DONE lasts
// one cycle and pulses `done`.
// Build option: define LSB_FIRST_EN to send din[0] first. The default build
// sends din[WIDTH-1] first. Timing is the same in both builds.
module bit_serializer #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 4000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ser_out,
  output logic             ser_clk,
  output logic             busy,
  output logic             done
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int BIT_W  = $clog2(WIDTH + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICK_DIV / 2);
  localparam logic [BIT_W-1:0]  BITS_ALL  = BIT_W'(WIDTH);
  localparam logic [BIT_W-1:0]  BITS_LAST = BIT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [TICK_W-1:0]  tick_q;
  logic [BIT_W-1:0]   bitcnt_q;
  logic [WIDTH-1:0]   shreg_q;
  logic               load_prev_q;
  logic               armed_q;
  logic               ser_out_q;
  logic               ser_clk_q;
  logic               busy_q;
  logic               done_q;

  logic               load_edge_d;
  logic               tick_wrap_d;
  logic [TICK_W-1:0]  tick_d;
  logic [WIDTH-1:0]   shreg_d;
  logic               first_bit_d;
  logic               next_bit_d;

  // armed_q stays low after reset until load has been seen low, so a load
  // level that was already high at reset release is not mistaken for an edge.
  assign load_edge_d = load & ~load_prev_q & armed_q;
  assign tick_wrap_d = (tick_q == TICK_LAST);
  assign tick_d      = tick_wrap_d ? '0 : tick_q + 1'b1;

`ifdef LSB_FIRST_EN
  assign shreg_d     = shreg_q >> 1;
  assign first_bit_d = din[0];
  assign next_bit_d  = shreg_d[0];
`else
  assign shreg_d     = shreg_q << 1;
  assign first_bit_d = din[WIDTH-1];
  assign next_bit_d  = shreg_d[WIDTH-1];
`endif

  // Frame FSM: edge detection, tick/bit counting, and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      load_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_clk_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      load_prev_q <= load;
      armed_q     <= armed_q | ~load;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_edge_d) begin
            shreg_q   <= din;
            bitcnt_q  <= BITS_ALL;
            tick_q    <= '0;
            ser_out_q <= first_bit_d;
            ser_clk_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          tick_q    <= tick_d;
          // ser_clk tracks the tick value the next cycle will hold, so it
          // stays aligned with the registered ser_out.
          ser_clk_q <= (tick_d >= TICK_HALF);
          if (tick_wrap_d) begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_q - 1'b1;
            if (bitcnt_q == BITS_LAST) begin
              ser_out_q <= 1'b0;
              ser_clk_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else begin
              ser_out_q <= next_bit_d;
            end
          end
        end
        DONE: begin
          // A load edge arriving in this cycle is dropped on purpose.
          tick_q    <= '0;
          ser_out_q <= 1'b0;
          ser_clk_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          tick_q    <= '0;
          ser_out_q <= 1'b0;
          ser_clk_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ser_out = ser_out_q;
  assign ser_clk = ser_clk_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer (WIDTH=8, TICK_DIV=4). Each stimulus pushes
// the expected ser_clk rise events (cycle and bit) and the expected done
// cycle into queues. A monitor on the falling edge pops and compares.
module tb_bit_serializer;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       load  = 1'b0;
  logic [7:0] din   = 8'h00;
  logic       ser_out;
  logic       ser_clk;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit_serializer #(.WIDTH(8), .TICK_DIV(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .load   (load),
    .ser_out(ser_out),
    .ser_clk(ser_clk),
    .busy   (busy),
    .done   (done)
  );

  typedef struct packed {
    int   cyc;
    logic b;
  } ev_t;

  ev_t bit_q[$];
  int  done_q[$];
  int  checks = 0;
  int  passes = 0;

`ifdef LSB_FIRST_EN
  localparam logic [7:0] SEQ_96 = 8'b0110_1001;
`else
  localparam logic [7:0] SEQ_96 = 8'b1001_0110;
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Bit order on the wire: seq[7] is sent first.
  function automatic logic [7:0] tx_order(input logic [7:0] d);
    logic [7:0] r;
`ifdef LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
`else
    r = d;
`endif
    return r;
  endfunction

  // m is the cycle in which load is first seen high.
  task automatic push_frame(input int m, input logic [7:0] seq);
    ev_t e;
    for (int i = 0; i < 8; i++) begin
      e.cyc = m + 3 + 4 * i;
      e.b   = seq[7-i];
      bit_q.push_back(e);
    end
    done_q.push_back(m + 33);
  endtask

  task automatic pulse(input logic [7:0] d, input bit expect_frame, input logic [7:0] seq);
    @(posedge clk); #1;
    din  = d;
    load = 1'b1;
    if (expect_frame) push_frame(cyc, seq);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  ev_t  mon_e;
  int   mon_d;
  logic sclk_prev = 1'b0;

  // Monitor: consumes expectations whenever the DUT presents a bit or done.
  always @(negedge clk) begin
    if (!reset) begin
      if (ser_clk && !sclk_prev) begin
        if (bit_q.size() == 0) check("unexpected ser_clk rise", cyc, -1);
        else begin
          mon_e = bit_q.pop_front();
          check("ser_clk rise cycle", cyc, mon_e.cyc);
          check("ser_out bit", int'(ser_out), int'(mon_e.b));
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected done", cyc, -1);
        else begin
          mon_d = done_q.pop_front();
          check("done cycle", cyc, mon_d);
          check("busy at done", int'(busy), 1);
          check("ser_out at done", int'(ser_out), 0);
        end
      end
    end
    sclk_prev = ser_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    // Reset state, with load already high while reset is asserted.
    #1 reset = 1'b1; load = 1'b1;
    #2;
    check("reset ser_out", int'(ser_out), 0);
    check("reset ser_clk", int'(ser_clk), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("held load at release ignored", int'(busy), 0);
    load = 1'b0;
    repeat (2) @(posedge clk);

    // Basic frame 1001_0110.
    pulse(8'b1001_0110, 1'b1, SEQ_96);
    check("busy in frame", int'(busy), 1);
    repeat (40) @(posedge clk);
    #1 check("busy after frame", int'(busy), 0);
    check("ser_out idle", int'(ser_out), 0);

    // Second load edge 10 cycles into a frame is ignored.
    pulse(8'b1001_0110, 1'b1, SEQ_96);
    repeat (8) @(posedge clk);
    pulse(8'hFF, 1'b0, 8'h00);
    check("busy through ignored edge", int'(busy), 1);
    repeat (40) @(posedge clk);

    // Load held high for 100 cycles: one frame only.
    @(posedge clk); #1;
    din  = 8'hA5;
    load = 1'b1;
    push_frame(cyc, tx_order(8'hA5));
    repeat (100) @(posedge clk);
    #1 load = 1'b0;
    repeat (5) @(posedge clk);

    // Reset 13 cycles into a frame.
    pulse(8'h3C, 1'b1, tx_order(8'h3C));
    repeat (12) @(posedge clk);
    #1 check("busy before abort", int'(busy), 1);
    #1 reset = 1'b1;
    #1;
    check("abort ser_out", int'(ser_out), 0);
    check("abort ser_clk", int'(ser_clk), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    bit_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(posedge clk);
    #1 check("idle after abort", int'(busy), 0);
    pulse(8'h3C, 1'b1, tx_order(8'h3C));
    repeat (40) @(posedge clk);

    // Load edge during the DONE cycle is dropped.
    pulse(8'h81, 1'b1, tx_order(8'h81));
    m = cyc - 1;
    repeat (32) @(posedge clk);
    #1;
    check("DONE cycle reached", cyc, m + 33);
    check("done high at dropped edge", int'(done), 1);
    load = 1'b1;
    @(posedge clk); #1;
    check("dropped edge idle", int'(busy), 0);
    @(posedge clk); #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    pulse(8'h5A, 1'b1, tx_order(8'h5A));
    repeat (40) @(posedge clk);

    check("bit queue drained", bit_q.size(), 0);
    check("done queue drained", done_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
